// File: rtl/afu_host_rx_split.sv
`default_nettype none
// ============================================================================
//  Module   : afu_host_rx_split
//  Purpose  : Splits the interleaved host RX AXI-S stream into a completion
//             source and a request source, each behind a 2-entry FIFO.
//  Revision : 1.0  initial release
// ============================================================================

module afu_host_rx_split_fifo #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o
);
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] tail_d;
    logic             w_pop;

    assign w_pop = pop_i && (cnt_q != 2'd0);

    // The head register always holds the oldest beat so the source is driven
    // straight from a flop; the tail only fills while the head is stalled.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    head_d = din_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && w_pop) begin
                    head_d = din_i;
                end else if (push_i) begin
                    tail_d = din_i;
                    cnt_d  = 2'd2;
                end else if (w_pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (w_pop && push_i) begin
                    head_d = tail_q;
                    tail_d = din_i;
                end else if (w_pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign dout_o  = head_q;
endmodule

module afu_host_rx_split #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic                in_tlast,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [DATA_W/8-1:0] in_tkeep,
    input  logic [USER_W-1:0]   in_tuser_vendor,

    output logic                cpl_tvalid,
    input  logic                cpl_tready,
    output logic                cpl_tlast,
    output logic [DATA_W-1:0]   cpl_tdata,
    output logic [DATA_W/8-1:0] cpl_tkeep,
    output logic [USER_W-1:0]   cpl_tuser_vendor,

    output logic                req_tvalid,
    input  logic                req_tready,
    output logic                req_tlast,
    output logic [DATA_W-1:0]   req_tdata,
    output logic [DATA_W/8-1:0] req_tkeep,
    output logic [USER_W-1:0]   req_tuser_vendor,

    output logic [CNT_W-1:0]    cpl_pkt_cnt,
    output logic [CNT_W-1:0]    req_pkt_cnt
);
    localparam int              C_KEEP_W = DATA_W / 8;
    localparam int              C_BEAT_W = DATA_W + C_KEEP_W + USER_W + 1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ROUTE_REQ = 1'b0,
        ROUTE_CPL = 1'b1
    } route_e;

    logic                sop_q;
    route_e              route_q;
    route_e              w_hdr_route;
    route_e              w_sel_route;
    logic                w_sel_full;
    logic                w_in_acc;

    logic [C_BEAT_W-1:0] w_in_beat;
    logic                w_cpl_push;
    logic                w_cpl_pop;
    logic                w_cpl_full;
    logic                w_cpl_valid;
    logic [C_BEAT_W-1:0] w_cpl_dout;
    logic                w_req_push;
    logic                w_req_pop;
    logic                w_req_full;
    logic                w_req_valid;
    logic [C_BEAT_W-1:0] w_req_dout;

    logic [CNT_W-1:0]    cpl_cnt_q;
    logic [CNT_W-1:0]    req_cnt_q;

    // CPL (0x0A) and CPLD (0x4A) share the low five fmt_type bits.
    assign w_hdr_route = (in_tdata[28:24] == 5'b01010) ? ROUTE_CPL : ROUTE_REQ;
    assign w_sel_route = sop_q ? w_hdr_route : route_q;
    assign w_sel_full  = (w_sel_route == ROUTE_CPL) ? w_cpl_full : w_req_full;
    assign in_tready   = !rst && !w_sel_full;
    assign w_in_acc    = in_tvalid && in_tready;

    assign w_in_beat   = {in_tdata, in_tkeep, in_tuser_vendor, in_tlast};
    assign w_cpl_push  = w_in_acc && (w_sel_route == ROUTE_CPL);
    assign w_req_push  = w_in_acc && (w_sel_route == ROUTE_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            sop_q   <= 1'b1;
            route_q <= ROUTE_REQ;
        end else if (w_in_acc) begin
            sop_q <= in_tlast;
            if (sop_q) begin
                route_q <= w_hdr_route;
            end
        end
    end

    afu_host_rx_split_fifo #(
        .WIDTH (C_BEAT_W)
    ) u_cpl_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_cpl_push),
        .din_i   (w_in_beat),
        .pop_i   (w_cpl_pop),
        .full_o  (w_cpl_full),
        .valid_o (w_cpl_valid),
        .dout_o  (w_cpl_dout)
    );

    afu_host_rx_split_fifo #(
        .WIDTH (C_BEAT_W)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_req_push),
        .din_i   (w_in_beat),
        .pop_i   (w_req_pop),
        .full_o  (w_req_full),
        .valid_o (w_req_valid),
        .dout_o  (w_req_dout)
    );

    // Valid is masked during reset so no handshake can complete in that cycle.
    assign cpl_tvalid = w_cpl_valid && !rst;
    assign req_tvalid = w_req_valid && !rst;
    assign {cpl_tdata, cpl_tkeep, cpl_tuser_vendor, cpl_tlast} = w_cpl_dout;
    assign {req_tdata, req_tkeep, req_tuser_vendor, req_tlast} = w_req_dout;
    assign w_cpl_pop  = cpl_tvalid && cpl_tready;
    assign w_req_pop  = req_tvalid && req_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpl_cnt_q <= '0;
            req_cnt_q <= '0;
        end else begin
            if (w_cpl_pop && cpl_tlast) begin
                cpl_cnt_q <= cpl_cnt_q + C_CNT_ONE;
            end
            if (w_req_pop && req_tlast) begin
                req_cnt_q <= req_cnt_q + C_CNT_ONE;
            end
        end
    end

    assign cpl_pkt_cnt = cpl_cnt_q;
    assign req_pkt_cnt = req_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_afu_host_rx_split.sv
`default_nettype none
// ============================================================================
//  Module   : tb_afu_host_rx_split
//  Purpose  : Self-checking bench: queue model per source plus directed and
//             random interleaved traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_afu_host_rx_split;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 10;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic          in_tlast = 1'b0;
    logic [DW-1:0] in_tdata = '0;
    logic [KW-1:0] in_tkeep = '0;
    logic [UW-1:0] in_tuser_vendor = '0;
    logic          cpl_tvalid, cpl_tlast;
    logic          cpl_tready = 1'b1;
    logic [DW-1:0] cpl_tdata;
    logic [KW-1:0] cpl_tkeep;
    logic [UW-1:0] cpl_tuser_vendor;
    logic          req_tvalid, req_tlast;
    logic          req_tready = 1'b1;
    logic [DW-1:0] req_tdata;
    logic [KW-1:0] req_tkeep;
    logic [UW-1:0] req_tuser_vendor;
    logic [CW-1:0] cpl_pkt_cnt, req_pkt_cnt;

    afu_host_rx_split #(.DATA_W(DW), .USER_W(UW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser_vendor(in_tuser_vendor),
        .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready), .cpl_tlast(cpl_tlast),
        .cpl_tdata(cpl_tdata), .cpl_tkeep(cpl_tkeep), .cpl_tuser_vendor(cpl_tuser_vendor),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
        .req_tdata(req_tdata), .req_tkeep(req_tkeep), .req_tuser_vendor(req_tuser_vendor),
        .cpl_pkt_cnt(cpl_pkt_cnt), .req_pkt_cnt(req_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t         qc[$];
    beat_t         qr[$];
    logic [CW-1:0] mc = '0;
    logic [CW-1:0] mr = '0;
    bit            m_sop = 1'b1;
    bit            m_route = 1'b0;
    bit            m_sel, m_rdy;
    beat_t         act;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            vc[int];
    bit            vr[int];
    bit            rnd = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit is_cpl(input logic [7:0] fmt);
        return fmt[4:0] == 5'b01010;
    endfunction

    // Model: one queue per source; a beat joins the queue chosen by its packet's
    // SOP header, leaves when the source handshakes; ready means "queue < 2".
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            qc.delete();
            qr.delete();
            mc = '0;
            mr = '0;
            m_sop = 1'b1;
            m_route = 1'b0;
        end else begin
            m_sel = m_sop ? is_cpl(in_tdata[31:24]) : m_route;
            m_rdy = m_sel ? (qc.size() < 2) : (qr.size() < 2);
            if (qc.size() > 0 && cpl_tready) begin
                if (qc[0].l) mc = mc + 1;
                void'(qc.pop_front());
            end
            if (qr.size() > 0 && req_tready) begin
                if (qr[0].l) mr = mr + 1;
                void'(qr.pop_front());
            end
            if (in_tvalid && m_rdy) begin
                if (m_sop) m_route = m_sel;
                m_sop = in_tlast;
                if (m_sel) qc.push_back({in_tdata, in_tkeep, in_tuser_vendor, in_tlast});
                else       qr.push_back({in_tdata, in_tkeep, in_tuser_vendor, in_tlast});
            end
        end
    end

    always @(negedge clk) begin
        m_sel = m_sop ? is_cpl(in_tdata[31:24]) : m_route;
        m_rdy = !rst && (m_sel ? (qc.size() < 2) : (qr.size() < 2));
        chk("in_tready", in_tready, m_rdy);
        chk("cpl_tvalid", cpl_tvalid, !rst && qc.size() > 0);
        chk("req_tvalid", req_tvalid, !rst && qr.size() > 0);
        if (cpl_tvalid && qc.size() > 0) begin
            act = {cpl_tdata, cpl_tkeep, cpl_tuser_vendor, cpl_tlast};
            total++;
            if (act !== qc[0]) begin
                bad++;
                $display("FAIL cpl_beat: got d=%h l=%b want d=%h l=%b", act.d[63:0], act.l, qc[0].d[63:0], qc[0].l);
            end
        end
        if (req_tvalid && qr.size() > 0) begin
            act = {req_tdata, req_tkeep, req_tuser_vendor, req_tlast};
            total++;
            if (act !== qr[0]) begin
                bad++;
                $display("FAIL req_beat: got d=%h l=%b want d=%h l=%b", act.d[63:0], act.l, qr[0].d[63:0], qr[0].l);
            end
        end
        chk("cpl_pkt_cnt", cpl_pkt_cnt, mc);
        chk("req_pkt_cnt", req_pkt_cnt, mr);
        vc[cyc] = cpl_tvalid;
        vr[cyc] = req_tvalid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            cpl_tready = ($urandom_range(0, 2) != 0);
            req_tready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic drive(input logic [7:0] hdr, input bit last);
        for (int i = 0; i < DW / 32; i++) in_tdata[i*32 +: 32] = $urandom;
        in_tdata[31:24] = hdr;
        in_tkeep        = {$urandom, $urandom};
        in_tuser_vendor = UW'($urandom);
        in_tlast        = last;
        in_tvalid       = 1'b1;
    endtask

    task automatic wait_acc();
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = in_tready;
            tick();
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no in_tready want accept within 500 cycles");
        end
    endtask

    task automatic send(input logic [7:0] hdr, input bit last);
        drive(hdr, last);
        wait_acc();
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tdata  = '0;
    endtask

    int           c0;
    int           nc, nr, len, t_end;
    logic [7:0]   hdr;
    logic [7:0]   hdr_tab [8] = '{8'h0A, 8'h4A, 8'h20, 8'h40, 8'h00, 8'h4A, 8'h0A, 8'h60};

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_tready", in_tready, 0);
        chk("rst_cpl_cnt", cpl_pkt_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_tready, 1);

        // 3-beat CPLD then 1-beat MRd, back to back
        @(posedge clk); #1;
        c0 = cyc;
        send(8'h4A, 0); send(8'h11, 0); send(8'h22, 1); send(8'h20, 1);
        idle();
        repeat (3) tick();
        chk("seq_cpl_c1", vc[c0+1], 1);
        chk("seq_cpl_c2", vc[c0+2], 1);
        chk("seq_cpl_c3", vc[c0+3], 1);
        chk("seq_cpl_c4", vc[c0+4], 0);
        chk("seq_req_c3", vr[c0+3], 0);
        chk("seq_req_c4", vr[c0+4], 1);
        chk("seq_cpl_cnt", cpl_pkt_cnt, 1);
        chk("seq_req_cnt", req_pkt_cnt, 1);

        // MWr whose second beat looks like a CPLD header
        send(8'h40, 0); send(8'h4A, 1);
        idle();
        repeat (3) tick();
        chk("mwr_cpl_cnt", cpl_pkt_cnt, 1);
        chk("mwr_req_cnt", req_pkt_cnt, 2);

        // Completion stalled: two beats fit, then the stream blocks
        cpl_tready = 1'b0;
        send(8'h4A, 0); send(8'h00, 0);
        drive(8'h20, 0);
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_tready", in_tready, 0);
        end
        chk("stall_req_tvalid", req_tvalid, 0);
        tick();
        cpl_tready = 1'b1;
        wait_acc();
        send(8'h20, 1);
        send(8'h20, 1);
        idle();
        repeat (4) tick();
        chk("stall_cpl_cnt", cpl_pkt_cnt, 2);
        chk("stall_req_cnt", req_pkt_cnt, 3);

        // Reset in the middle of a CPLD
        send(8'h4A, 0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cpl_tvalid", cpl_tvalid, 0);
        chk("midrst_req_tvalid", req_tvalid, 0);
        chk("midrst_cpl_cnt", cpl_pkt_cnt, 0);
        chk("midrst_req_cnt", req_pkt_cnt, 0);
        tick();
        c0 = cyc;
        send(8'h0A, 1);
        idle();
        tick();
        chk("post_rst_cpl_c1", vc[c0+1], 1);
        chk("post_rst_cpl_cnt", cpl_pkt_cnt, 1);

        // Counter wrap on simultaneous delivery
        cpl_tready = 1'b0;
        req_tready = 1'b0;
        send(8'h0A, 1); send(8'h20, 1);
        idle();
        @(negedge clk); #1;
        force dut.cpl_cnt_q = '1;
        force dut.req_cnt_q = '1;
        mc = '1;
        mr = '1;
        #1;
        release dut.cpl_cnt_q;
        release dut.req_cnt_q;
        tick();
        cpl_tready = 1'b1;
        req_tready = 1'b1;
        tick();
        chk("wrap_cpl_cnt", cpl_pkt_cnt, 0);
        chk("wrap_req_cnt", req_pkt_cnt, 0);

        // Random interleaved traffic with random backpressure
        nc = 0;
        nr = 0;
        rnd = 1'b1;
        t_end = cyc + 10000;
        while (cyc < t_end) begin
            len = $urandom_range(1, 4);
            hdr = hdr_tab[$urandom_range(0, 7)];
            if (is_cpl(hdr)) nc++; else nr++;
            for (int b = 0; b < len; b++) begin
                if (b == 0) send(hdr, len == 1);
                else        send(hdr_tab[$urandom_range(0, 7)], b == len - 1);
                if ($urandom_range(0, 4) == 0) begin
                    idle();
                    tick();
                end
            end
        end
        idle();
        rnd = 1'b0;
        cpl_tready = 1'b1;
        req_tready = 1'b1;
        repeat (6) tick();
        chk("rand_cpl_cnt", cpl_pkt_cnt, nc);
        chk("rand_req_cnt", req_pkt_cnt, nr);
        chk("rand_cpl_drained", cpl_tvalid, 0);
        chk("rand_req_drained", req_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
